bp_update_ctrl: RTL and testbench
=================================

Name: bp_update_ctrl

Overview:
Branch-resolution and predictor-maintenance controller between the M stage and the BHT/PHT predictor.
- Detects mispredictions in M and generates the front-end flush/redirect.
- Queues predictor-update requests so resolution never collides with the single-ported table update path.
- Sequences a multi-cycle table initialisation walk after reset and on software clear; keeps branch/mispredict statistics.

Parameters:
BHT_DEPTH, 10, log2 of BHT entries; width of init_idx and index field of upd_pc
PHT_DEPTH, 6, log2 of PHT entries (informational; init walk covers 2^BHT_DEPTH >= 2^PHT_DEPTH)
FIFO_DEPTH, 4, update-queue entries; power of two, >= 2
CNT_W, 32, statistics counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
stallM  in  1  M stage held; no resolution accepted this cycle
branchM  in  1  instruction in M is a conditional branch
pcM  in  32  PC of the branch in M
pred_takeM  in  1  prediction carried down the pipe
actual_takeM  in  1  resolved direction
targetM  in  32  resolved taken target
clear_req  in  1  pulse: request full predictor clear
flush_out  out  1  mispredict: flush F/D/E
redirect_pc  out  32  fetch PC on mispredict
stall_req  out  1  queue full: hold M and earlier
busy  out  1  init/clear in progress: hold fetch
upd_valid  out  1  update request to predictor
upd_pc  out  32  PC of update
upd_taken  out  1  direction of update
upd_ready  in  1  predictor accepts update this cycle
init_we  out  1  write reset value at init_idx (BHT<=0, PHT<=weakly taken)
init_idx  out  BHT_DEPTH  table index being initialised
br_cnt  out  CNT_W  accepted branches
mis_cnt  out  CNT_W  accepted mispredictions

Behaviour:
- Reset (rst=0, async): state=INIT, init_idx=0, FIFO empty, br_cnt=mis_cnt=0.
- Reset output values: flush_out=0, stall_req=0, upd_valid=0, busy=1, init_we=1.
- accept = branchM & ~stallM.
- mispredict = accept & (pred_takeM != actual_takeM).
- flush_out = mispredict, combinational, same cycle.
- redirect_pc = actual_takeM ? targetM : pcM+8 (delay slot). Value is don't-care when flush_out=0.
- stall_req = branchM & fifo_full, combinational. Conservative: asserted even if a dequeue occurs the same cycle.
- Enqueue {pcM, actual_takeM} on accept. stall_req feeds stallM, so an entry is never dropped.
- Dequeue on upd_valid & upd_ready; upd_valid = ~empty & (state==RUN). Head is held stable while upd_ready=0.
- Queue ordering is strict FIFO. Simultaneous enqueue/dequeue leaves the count unchanged. Pointers wrap modulo FIFO_DEPTH.
- States:
  - INIT: busy=1, init_we=1, init_idx increments every cycle; at 2^BHT_DEPTH-1 -> RUN next cycle (walk = 2^BHT_DEPTH cycles). Queue not drained; enqueue still allowed.
  - RUN: busy=0, init_we=0, updates drain. clear_req=1 -> DRAIN.
  - DRAIN: busy=1, updates still drain, no new walk yet. When FIFO empty and no handshake this cycle -> INIT with init_idx=0.
- clear_req is ignored in INIT and DRAIN.
- Reset asserted mid-walk restarts at init_idx=0.
- Counters:
  - br_cnt += accept; mis_cnt += mispredict.
  - Both saturate at all-ones.
  - Cleared only by rst, not by clear_req.

Decomposition:
- Shared package bp_pkg:
  - state encoding INIT/RUN/DRAIN.
  - PHT counter encodings (SNT=00, WNT=01, WT=11, ST=10).
  - PHT init constant WT.
  - delay-slot offset 8.
- One sub-module bp_upd_fifo: parameterised sync FIFO (width 33, depth FIFO_DEPTH) exposing full/empty.
- FSM, flush logic and counters stay in the top.

Test Plan:
- Reset release, BHT_DEPTH=10 -> busy=1 and init_we=1 for exactly 1024 cycles, init_idx 0..1023 then busy=0; upd_valid=0 throughout.
- branchM=1, pcM=0x0040_0010, pred=0, actual=1, targetM=0x0040_0100 -> flush_out=1, redirect_pc=0x0040_0100 same cycle; mis_cnt=1, br_cnt=1; next cycle upd_valid=1, upd_pc=0x0040_0010, upd_taken=1.
- Same branch, pred=1, actual=0 -> redirect_pc=0x0040_0018.
- upd_ready=0, five back-to-back branches with FIFO_DEPTH=4 -> stall_req=1 on the fifth. Raise upd_ready: four updates exit in order, then fifth enqueued; no loss, no duplication.
- clear_req with 3 queued entries and upd_ready=1 -> DRAIN for 3 handshakes, then INIT walk of 1024; counters unchanged.
- rst=0 pulse at init_idx=500 -> init_idx=0 immediately. br_cnt preset near max plus extra branches -> holds at 0xFFFF_FFFF.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared definitions for the branch-resolution / predictor-maintenance slice.
// Contents:
//   bpState_t      - controller state (init walk, normal run, drain before clear)
//   phtCnt_t       - 2-bit PHT counter encodings
//   PHT_INIT       - value the init walk writes into every PHT entry
//   DELAY_SLOT_OFS - fall-through offset for a not-taken branch (skips delay slot)
//   updEntry_t     - one update-queue entry {pc, taken}
package bp_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } bpState_t;

    typedef enum logic [1:0] {
        PHT_SNT = 2'b00,
        PHT_WNT = 2'b01,
        PHT_WT  = 2'b11,
        PHT_ST  = 2'b10
    } phtCnt_t;

    localparam phtCnt_t     PHT_INIT       = PHT_WT;
    localparam logic [31:0] DELAY_SLOT_OFS = 32'd8;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
    } updEntry_t;

    localparam int unsigned UPD_ENTRY_W = $bits(updEntry_t);

endpackage

// File: rtl/bp_upd_fifo.sv
// Synchronous FIFO holding predictor-update requests.
// Ports:
//   clk, rst        - clock, asynchronous active-low reset (empties the queue)
//   push, pushData  - write request and data
//   pop             - read request; head advances when not empty
//   popData         - current head entry (stable until popped)
//   full, empty     - occupancy flags
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module bp_upd_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] popData,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depthCheck
        $error("bp_upd_fifo: DEPTH must be a power of two and >= 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic [PW:0]      count;
    logic             wrEn;
    logic             rdEn;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rdEn    = pop & ~empty;
    // A push while full is only taken if a slot frees up in the same cycle.
    assign wrEn    = push & (~full | rdEn);
    assign popData = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrPtr] <= pushData;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (wrEn) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (rdEn) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({wrEn, rdEn})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bp_update_ctrl.sv
// Branch-resolution and predictor-maintenance controller (M stage -> BHT/PHT).
// Ports:
//   clk, rst                  - clock, asynchronous active-low reset
//   stallM, branchM, pcM      - M-stage handshake and branch PC
//   pred_takeM, actual_takeM  - predicted / resolved direction
//   targetM                   - resolved taken target
//   clear_req                 - pulse: clear the whole predictor
//   flush_out, redirect_pc    - same-cycle mispredict flush and fetch redirect
//   stall_req                 - update queue full: hold M and earlier
//   busy                      - init walk or clear in progress: hold fetch
//   upd_valid/upd_pc/upd_taken/upd_ready - predictor update handshake
//   init_we, init_idx         - table initialisation write strobe and index
//   br_cnt, mis_cnt           - saturating branch / mispredict statistics
module bp_update_ctrl
    import bp_pkg::*;
#(
    parameter int unsigned BHT_DEPTH  = 10,
    parameter int unsigned PHT_DEPTH  = 6,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stallM,
    input  logic                 branchM,
    input  logic [31:0]          pcM,
    input  logic                 pred_takeM,
    input  logic                 actual_takeM,
    input  logic [31:0]          targetM,
    input  logic                 clear_req,
    output logic                 flush_out,
    output logic [31:0]          redirect_pc,
    output logic                 stall_req,
    output logic                 busy,
    output logic                 upd_valid,
    output logic [31:0]          upd_pc,
    output logic                 upd_taken,
    input  logic                 upd_ready,
    output logic                 init_we,
    output logic [BHT_DEPTH-1:0] init_idx,
    output logic [CNT_W-1:0]     br_cnt,
    output logic [CNT_W-1:0]     mis_cnt
);

    // The walk indexes by BHT size, so it must also cover every PHT entry.
    if (PHT_DEPTH > BHT_DEPTH) begin : g_depthCheck
        $error("bp_update_ctrl: PHT_DEPTH must not exceed BHT_DEPTH");
    end

    bpState_t             state;
    bpState_t             stateNext;
    logic [BHT_DEPTH-1:0] initIdx;
    logic                 accept;
    logic                 mispredict;
    logic                 drainEn;
    logic                 updFire;
    logic                 fifoFull;
    logic                 fifoEmpty;
    updEntry_t            newEntry;
    updEntry_t            headEntry;

    // ---------------- resolution / flush ----------------
    assign accept      = branchM & ~stallM;
    assign mispredict  = accept & (pred_takeM != actual_takeM);
    assign flush_out   = mispredict;
    assign redirect_pc = actual_takeM ? targetM : (pcM + DELAY_SLOT_OFS);

    // Conservative: a dequeue in the same cycle does not release the stall.
    assign stall_req   = branchM & fifoFull;

    // ---------------- update queue ----------------
    assign newEntry = '{pc: pcM, taken: actual_takeM};

    bp_upd_fifo #(
        .WIDTH (UPD_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (accept),
        .pushData (newEntry),
        .pop      (updFire),
        .popData  (headEntry),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    assign upd_valid = drainEn & ~fifoEmpty;
    assign updFire   = upd_valid & upd_ready;
    assign upd_pc    = headEntry.pc;
    assign upd_taken = headEntry.taken;
    assign init_idx  = initIdx;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_INIT;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        busy      = 1'b1;
        init_we   = 1'b0;
        drainEn   = 1'b0;
        case (state)
            ST_INIT: begin
                init_we = 1'b1;
                if (initIdx == '1) begin
                    stateNext = ST_RUN;
                end
            end
            ST_RUN: begin
                busy    = 1'b0;
                drainEn = 1'b1;
                if (clear_req) begin
                    stateNext = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                drainEn = 1'b1;
                // A handshake implies a non-empty queue, so checking empty
                // alone also guarantees no handshake this cycle.
                if (fifoEmpty) begin
                    stateNext = ST_INIT;
                end
            end
            default: begin
                stateNext = ST_INIT;
            end
        endcase
    end

    // The index rests at zero outside INIT so a new walk always starts at 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            initIdx <= '0;
        end else if (state == ST_INIT) begin
            initIdx <= initIdx + 1'b1;
        end else begin
            initIdx <= '0;
        end
    end

    // ---------------- statistics ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_cnt  <= '0;
            mis_cnt <= '0;
        end else begin
            if (accept && (br_cnt != '1)) begin
                br_cnt <= br_cnt + CNT_W'(1);
            end
            if (mispredict && (mis_cnt != '1)) begin
                mis_cnt <= mis_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bp_update_ctrl.sv
module tb_bp_update_ctrl;

    localparam int BHT  = 10;
    localparam int FD   = 4;
    localparam int CW   = 8;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          stallM, branchM, pred_takeM, actual_takeM, clear_req, upd_ready;
    logic [31:0]   pcM, targetM;
    logic          flush_out, stall_req, busy, upd_valid, upd_taken, init_we;
    logic [31:0]   redirect_pc, upd_pc;
    logic [BHT-1:0] init_idx;
    logic [CW-1:0] br_cnt, mis_cnt;

    int compared   = 0;
    int mismatched = 0;
    int expBr      = 0;
    int expMis     = 0;
    logic [32:0] sbq[$];
    logic [32:0] expEntry;

    always #5 clk = ~clk;

    bp_update_ctrl #(
        .BHT_DEPTH  (BHT),
        .PHT_DEPTH  (6),
        .FIFO_DEPTH (FD),
        .CNT_W      (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stallM       (stallM),
        .branchM      (branchM),
        .pcM          (pcM),
        .pred_takeM   (pred_takeM),
        .actual_takeM (actual_takeM),
        .targetM      (targetM),
        .clear_req    (clear_req),
        .flush_out    (flush_out),
        .redirect_pc  (redirect_pc),
        .stall_req    (stall_req),
        .busy         (busy),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken),
        .upd_ready    (upd_ready),
        .init_we      (init_we),
        .init_idx     (init_idx),
        .br_cnt       (br_cnt),
        .mis_cnt      (mis_cnt)
    );

    // Stimulus-side bookkeeping: record an accepted branch in scoreboard and model.
    task automatic note_accept();
        sbq.push_back({pcM, actual_takeM});
        if (expBr < MAXC) expBr++;
        if ((pred_takeM != actual_takeM) && (expMis < MAXC)) expMis++;
    endtask

    task automatic set_branch(input logic [31:0] pc, input logic pr, input logic ac,
                              input logic [31:0] tg);
        branchM = 1'b1; pcM = pc; pred_takeM = pr; actual_takeM = ac; targetM = tg;
    endtask

    task automatic test_reset();
        int walkCnt, bad;
        rst = 1'b0; stallM = 1'b0; branchM = 1'b0; pcM = '0; pred_takeM = 1'b0;
        actual_takeM = 1'b0; targetM = '0; clear_req = 1'b0; upd_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        compared++; if ({busy, init_we} !== 2'b11) begin mismatched++;
            $display("FAIL reset_busy_we: got %b expected 11", {busy, init_we}); end
        compared++; if ({flush_out, stall_req, upd_valid} !== 3'b000) begin mismatched++;
            $display("FAIL reset_outs: got %b expected 000", {flush_out, stall_req, upd_valid}); end
        compared++; if (init_idx !== '0) begin mismatched++;
            $display("FAIL reset_idx: got %0d expected 0", init_idx); end
        compared++; if ({br_cnt, mis_cnt} !== '0) begin mismatched++;
            $display("FAIL reset_cnt: got %h/%h expected 0/0", br_cnt, mis_cnt); end
        @(negedge clk); rst = 1'b1; #1;
        walkCnt = 0; bad = 0;
        for (int c = 0; c < 2000 && busy; c++) begin
            if (!init_we || init_idx !== walkCnt[BHT-1:0] || upd_valid) bad++;
            walkCnt++;
            @(negedge clk); #1;
        end
        compared++; if (walkCnt !== 1024) begin mismatched++;
            $display("FAIL walk_len: got %0d expected 1024", walkCnt); end
        compared++; if (bad !== 0) begin mismatched++;
            $display("FAIL walk_seq: got %0d bad cycles expected 0", bad); end
        compared++; if ({busy, init_we} !== 2'b00) begin mismatched++;
            $display("FAIL run_after_walk: got %b expected 00", {busy, init_we}); end
    endtask

    task automatic test_mispredict();
        @(negedge clk);
        upd_ready = 1'b0; stallM = 1'b0;
        set_branch(32'h0040_0010, 1'b0, 1'b1, 32'h0040_0100); #1;
        compared++; if (flush_out !== 1'b1) begin mismatched++;
            $display("FAIL mp_flush: got %b expected 1", flush_out); end
        compared++; if (redirect_pc !== 32'h0040_0100) begin mismatched++;
            $display("FAIL mp_redirect_taken: got %h expected 00400100", redirect_pc); end
        note_accept();
        @(negedge clk); branchM = 1'b0; #1;
        compared++; if ({br_cnt, mis_cnt} !== {CW'(1), CW'(1)}) begin mismatched++;
            $display("FAIL mp_cnt: got %0d/%0d expected 1/1", br_cnt, mis_cnt); end
        compared++; if ({upd_valid, upd_pc, upd_taken} !== {1'b1, 32'h0040_0010, 1'b1}) begin
            mismatched++;
            $display("FAIL mp_upd: got v=%b pc=%h t=%b expected v=1 pc=00400010 t=1",
                     upd_valid, upd_pc, upd_taken); end
    endtask

    task automatic test_delay_slot();
        @(negedge clk);
        set_branch(32'h0040_0010, 1'b1, 1'b0, 32'h0040_0100); #1;
        compared++; if ({flush_out, redirect_pc} !== {1'b1, 32'h0040_0018}) begin mismatched++;
            $display("FAIL ds_redirect: got f=%b %h expected f=1 00400018", flush_out, redirect_pc); end
        note_accept();
        @(negedge clk);
        set_branch(32'h0040_0020, 1'b1, 1'b1, 32'h0040_0200); #1;
        compared++; if (flush_out !== 1'b0) begin mismatched++;
            $display("FAIL correct_pred_flush: got %b expected 0", flush_out); end
        note_accept();
        @(negedge clk);
        set_branch(32'h0040_0030, 1'b0, 1'b1, 32'h0040_0300); stallM = 1'b1; #1;
        compared++; if (flush_out !== 1'b0) begin mismatched++;
            $display("FAIL stalled_flush: got %b expected 0", flush_out); end
        @(negedge clk); branchM = 1'b0; stallM = 1'b0; upd_ready = 1'b1;
        for (int c = 0; c < 20 && sbq.size() != 0; c++) begin
            #1;
            if (upd_valid && upd_ready) begin
                expEntry = sbq.pop_front();
                compared++; if ({upd_pc, upd_taken} !== expEntry) begin mismatched++;
                    $display("FAIL ds_drain: got %h expected %h", {upd_pc, upd_taken}, expEntry); end
            end
            @(negedge clk);
        end
        #1;
        compared++; if ({br_cnt, mis_cnt} !== {CW'(expBr), CW'(expMis)}) begin mismatched++;
            $display("FAIL ds_cnt: got %0d/%0d expected %0d/%0d", br_cnt, mis_cnt, expBr, expMis); end
        compared++; if ((sbq.size() != 0) || upd_valid) begin mismatched++;
            $display("FAIL ds_empty: got left=%0d v=%b expected 0/0", sbq.size(), upd_valid); end
    endtask

    task automatic test_back_to_back();
        int hs;
        logic pending;
        upd_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            set_branch(32'h0000_1000 + 32'(k * 4), k[0], k[0], 32'h0000_8000);
            stallM = 1'b0; #1;
            compared++; if (stall_req !== (k == 4)) begin mismatched++;
                $display("FAIL b2b_stall_%0d: got %b expected %b", k, stall_req, (k == 4)); end
            stallM = stall_req; #1;
            if (!stallM) note_accept();
        end
        @(negedge clk); upd_ready = 1'b1; pending = 1'b1; hs = 0;
        for (int c = 0; c < 30 && (pending || sbq.size() != 0); c++) begin
            stallM = 1'b0; #1;
            if (c == 0) begin
                compared++; if (stall_req !== 1'b1) begin mismatched++;
                    $display("FAIL b2b_conservative: got %b expected 1", stall_req); end
            end
            stallM = stall_req; #1;
            if (upd_valid && upd_ready) begin
                hs++;
                compared++;
                if (sbq.size() == 0) begin mismatched++;
                    $display("FAIL b2b_dup: got %h expected no update", {upd_pc, upd_taken}); end
                else begin
                    expEntry = sbq.pop_front();
                    if ({upd_pc, upd_taken} !== expEntry) begin mismatched++;
                        $display("FAIL b2b_order: got %h expected %h", {upd_pc, upd_taken}, expEntry); end
                end
            end
            if (branchM && !stallM) begin note_accept(); pending = 1'b0; end
            @(negedge clk);
            if (!pending) branchM = 1'b0;
        end
        stallM = 1'b0; #1;
        compared++; if ((hs !== 5) || upd_valid) begin mismatched++;
            $display("FAIL b2b_total: got %0d updates v=%b expected 5 v=0", hs, upd_valid); end
    endtask

    task automatic test_clear();
        int drainHs, walkCnt, bad;
        logic [BHT-1:0] firstIdx;
        upd_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            set_branch(32'h0000_3000 + 32'(k * 8), 1'b0, 1'b0, '0); stallM = 1'b0; #1;
            note_accept();
        end
        @(negedge clk); branchM = 1'b0; clear_req = 1'b1; #1;
        compared++; if (busy !== 1'b0) begin mismatched++;
            $display("FAIL clr_run: got busy=%b expected 0", busy); end
        @(negedge clk); clear_req = 1'b0; upd_ready = 1'b1;
        drainHs = 0; bad = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (init_we) break;
            if (!busy) bad++;
            if (upd_valid && upd_ready) begin
                drainHs++;
                expEntry = (sbq.size() != 0) ? sbq.pop_front() : 33'h0;
                compared++; if ({upd_pc, upd_taken} !== expEntry) begin mismatched++;
                    $display("FAIL clr_drain: got %h expected %h", {upd_pc, upd_taken}, expEntry); end
            end
            @(negedge clk);
        end
        compared++; if ((drainHs !== 3) || (bad !== 0)) begin mismatched++;
            $display("FAIL clr_drain_cnt: got %0d hs %0d notbusy expected 3/0", drainHs, bad); end
        firstIdx = init_idx; walkCnt = 0;
        for (int c = 0; c < 2000 && busy; c++) begin
            if (init_we) walkCnt++;
            if (upd_valid) bad++;
            @(negedge clk); #1;
        end
        compared++; if ((walkCnt !== 1024) || (firstIdx !== '0) || (bad !== 0)) begin mismatched++;
            $display("FAIL clr_walk: got %0d cycles idx0=%0d bad=%0d expected 1024/0/0",
                     walkCnt, firstIdx, bad); end
        compared++; if ({br_cnt, mis_cnt} !== {CW'(expBr), CW'(expMis)}) begin mismatched++;
            $display("FAIL clr_cnt_kept: got %0d/%0d expected %0d/%0d", br_cnt, mis_cnt, expBr, expMis); end
    endtask

    task automatic test_reset_midwalk();
        int c;
        @(negedge clk); clear_req = 1'b1; upd_ready = 1'b0;
        @(negedge clk); clear_req = 1'b0;
        for (c = 0; c < 2000; c++) begin
            #1;
            if (init_we && (init_idx == 10'd500)) break;
            @(negedge clk);
        end
        rst = 1'b0; #1;
        expBr = 0; expMis = 0; sbq.delete();
        compared++; if ({busy, init_we, init_idx} !== {2'b11, 10'd0} || c >= 2000) begin mismatched++;
            $display("FAIL midwalk_rst: got b=%b we=%b idx=%0d expected 1/1/0", busy, init_we, init_idx); end
        compared++; if ({br_cnt, mis_cnt} !== '0) begin mismatched++;
            $display("FAIL midwalk_cnt: got %0d/%0d expected 0/0", br_cnt, mis_cnt); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); #1;
        compared++; if (init_idx !== 10'd1) begin mismatched++;
            $display("FAIL midwalk_restart: got %0d expected 1", init_idx); end
        for (int k = 0; k < 1100 && busy; k++) begin @(negedge clk); #1; end
        compared++; if (busy !== 1'b0) begin mismatched++;
            $display("FAIL midwalk_done: got busy=%b expected 0", busy); end
    endtask

    task automatic test_saturation();
        upd_ready = 1'b1;
        for (int i = 0; i < 260; i++) begin
            @(negedge clk);
            set_branch(32'h0000_4000 + 32'(i * 4), 1'b0, 1'b1, 32'h0000_9000);
            stallM = 1'b0; #1;
            stallM = stall_req; #1;
            if (i == 254 || i == 255) begin
                compared++; if ({br_cnt, mis_cnt} !== {CW'(expBr), CW'(expMis)}) begin mismatched++;
                    $display("FAIL sat_%0d: got %0d/%0d expected %0d/%0d",
                             i, br_cnt, mis_cnt, expBr, expMis); end
            end
            if (upd_valid && upd_ready) begin
                expEntry = (sbq.size() != 0) ? sbq.pop_front() : 33'h0;
                compared++; if ({upd_pc, upd_taken} !== expEntry) begin mismatched++;
                    $display("FAIL sat_upd: got %h expected %h", {upd_pc, upd_taken}, expEntry); end
            end
            if (!stallM) note_accept();
        end
        @(negedge clk); branchM = 1'b0; stallM = 1'b0;
        for (int c = 0; c < 20 && sbq.size() != 0; c++) begin
            #1;
            if (upd_valid && upd_ready) begin
                expEntry = sbq.pop_front();
                compared++; if ({upd_pc, upd_taken} !== expEntry) begin mismatched++;
                    $display("FAIL sat_drain: got %h expected %h", {upd_pc, upd_taken}, expEntry); end
            end
            @(negedge clk);
        end
        #1;
        compared++; if ({br_cnt, mis_cnt} !== {CW'(MAXC), CW'(MAXC)}) begin mismatched++;
            $display("FAIL sat_hold: got %h/%h expected %h/%h", br_cnt, mis_cnt, MAXC, MAXC); end
        compared++; if ((sbq.size() != 0) || upd_valid) begin mismatched++;
            $display("FAIL sat_empty: got left=%0d v=%b expected 0/0", sbq.size(), upd_valid); end
    endtask

    initial begin
        test_reset();
        test_mispredict();
        test_delay_slot();
        test_back_to_back();
        test_clear();
        test_reset_midwalk();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
